tcm_ctrl: RTL

TCM_CTRL -- requirements
Module: tcm_ctrl

---
 rtl/tcm_pkg.sv | 10 +
 rtl/tcm_bank.sv | 37 +++
 rtl/tcm_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/tcm_pkg.sv
// Shared widths and default geometry for the tightly-coupled memory controller.
// Pure constants: no logic, no latency, no flow control.
package tcm_pkg;
  localparam int WORD_W     = 32;
  localparam int BEN_W      = 4;
  localparam int AW_DEF     = 14;
  localparam int NBANK_DEF  = 2;
  localparam int STARVE_DEF = 3;
  localparam int CNT_W      = 4;
endpackage

// File: rtl/tcm_bank.sv
// One 32-bit byte-enabled SRAM bank; read data registered one cycle after en&!we.
// No backpressure: every enabled cycle is accepted; rdata holds until the next read.
module tcm_bank
  import tcm_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [BEN_W-1:0]  ben,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_q [2**AW];
  logic [WORD_W-1:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (en && !we) rdata_d = mem_q[addr];
  end

  // Array is deliberately left unreset so contents survive a CPU reset.
  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
    if (en && we) begin
      for (int b = 0; b < BEN_W; b++) begin
        if (ben[b]) mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/tcm_ctrl.sv
// Arbitrates fetch and data ports onto NBANK shared banks; one access per cycle, rvalid 1 cycle after gnt.
// Data wins ties; fetch is forced through after STARVE consecutive losses. Requesters hold until gnt.
module tcm_ctrl
  import tcm_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int NBANK  = NBANK_DEF,
  parameter int STARVE = STARVE_DEF
) (
  input  logic                    clk,
  input  logic                    cpurst,
  input  logic                    i_req,
  input  logic [31:0]             i_addr,
  output logic                    i_gnt,
  output logic                    i_rvalid,
  output logic [WORD_W*NBANK-1:0] i_rdata,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [BEN_W-1:0]        d_ben,
  input  logic [31:0]             d_addr,
  input  logic [WORD_W-1:0]       d_wdata,
  output logic                    d_gnt,
  output logic                    d_rvalid,
  output logic [WORD_W-1:0]       d_rdata
);

  localparam int LB = $clog2(NBANK);
  localparam int BW = (LB > 0) ? LB : 1;

  logic [29:0]              d_word;
  logic [BW-1:0]            d_bank;
  logic [AW-1:0]            d_row, i_row, bank_addr;
  logic [NBANK-1:0]         bank_en;
  logic                     bank_we;
  logic [WORD_W*NBANK-1:0]  bank_rd;
  logic [WORD_W-1:0]        d_sel;
  logic                     starve_hit, i_rv, d_rv;
  logic                     unused_addr;

  logic [CNT_W-1:0]         starve_q, starve_d;
  logic                     i_rvalid_q, i_rvalid_d, d_rvalid_q, d_rvalid_d;
  logic [BW-1:0]            d_bank_q, d_bank_d;
  logic [WORD_W*NBANK-1:0]  i_hold_q, i_hold_d;
  logic [WORD_W-1:0]        d_hold_q, d_hold_d;

  assign d_word      = d_addr[31:2];
  assign d_bank      = BW'(d_word & 30'(NBANK - 1));
  assign d_row       = AW'(d_word >> LB);
  assign i_row       = AW'(i_addr >> (LB + 2));
  assign unused_addr = ^d_addr[1:0];

  assign starve_hit = (starve_q == CNT_W'(STARVE));

  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!cpurst) begin
      i_gnt = i_req && (!d_req || starve_hit);
      d_gnt = d_req && !i_gnt;
    end
  end

  always_comb begin
    starve_d = '0;
    if (i_req && !i_gnt) starve_d = starve_hit ? starve_q : starve_q + 1'b1;
  end

  assign bank_addr = i_gnt ? i_row : d_row;
  assign bank_we   = d_gnt && d_we;

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    assign bank_en[b] = i_gnt || (d_gnt && (d_bank == BW'(b)));
    tcm_bank #(.AW(AW)) u_bank (
      .clk   (clk),
      .en    (bank_en[b]),
      .we    (bank_we),
      .ben   (d_ben),
      .addr  (bank_addr),
      .wdata (d_wdata),
      .rdata (bank_rd[b*WORD_W +: WORD_W])
    );
  end

  // A read granted just before reset must not surface while reset is held.
  assign i_rv  = i_rvalid_q && !cpurst;
  assign d_rv  = d_rvalid_q && !cpurst;
  assign d_sel = bank_rd[d_bank_q*WORD_W +: WORD_W];

  always_comb begin
    i_rvalid_d = i_gnt;
    d_rvalid_d = d_gnt && !d_we;
    d_bank_d   = d_gnt ? d_bank : d_bank_q;
    i_hold_d   = i_rv ? bank_rd : i_hold_q;
    d_hold_d   = d_rv ? d_sel : d_hold_q;
  end

  always_ff @(posedge clk) begin
    if (cpurst) begin
      starve_q   <= '0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      d_bank_q   <= '0;
      i_hold_q   <= '0;
      d_hold_q   <= '0;
    end else begin
      starve_q   <= starve_d;
      i_rvalid_q <= i_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
      d_bank_q   <= d_bank_d;
      i_hold_q   <= i_hold_d;
      d_hold_q   <= d_hold_d;
    end
  end

  assign i_rvalid = i_rv;
  assign d_rvalid = d_rv;
  assign i_rdata  = i_rv ? bank_rd : i_hold_q;
  assign d_rdata  = d_rv ? d_sel : d_hold_q;

endmodule
